// File: rtl/bus_resp_pkg.sv
// Shared types and constants for the 68000 DTACK/BERR responder.
package bus_resp_pkg;

  localparam int WAIT_W = 4;   // width of the per-region wait counter
  localparam int TMO_W  = 16;  // width of the bus-timeout counter

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    ERR
  } state_t;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_ROM,
    REG_RAM,
    REG_DRAM,
    REG_IO,
    REG_CAN
  } region_t;

  // Resolves overlapping decoder selects: ROM > RAM > DRAM > IO > CAN.
  function automatic region_t decode_region(input logic rom, input logic ram,
                                            input logic dram, input logic io,
                                            input logic can);
    if (rom)       return REG_ROM;
    else if (ram)  return REG_RAM;
    else if (dram) return REG_DRAM;
    else if (io)   return REG_IO;
    else if (can)  return REG_CAN;
    else           return REG_NONE;
  endfunction

endpackage

// File: rtl/bus_dtack_responder_if.sv
// Bus-side signals between the CPU/address decoder and the DTACK responder.
interface bus_dtack_responder_if;

  logic AS_L;
  logic OnChipRomSelect_H;
  logic OnChipRamSelect_H;
  logic DramSelect_H;
  logic IOSelect_H;
  logic CanBusSelect_H;
  logic DramDtack_L;
  logic CanBusDtack_L;
  logic DtackOut_L;
  logic BERR_L;
  logic Busy_H;

  // Responder view: consumes strobes/selects/external acks, drives termination.
  modport slave (
    input  AS_L, OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H,
           IOSelect_H, CanBusSelect_H, DramDtack_L, CanBusDtack_L,
    output DtackOut_L, BERR_L, Busy_H
  );

  // CPU/decoder view.
  modport master (
    output AS_L, OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H,
           IOSelect_H, CanBusSelect_H, DramDtack_L, CanBusDtack_L,
    input  DtackOut_L, BERR_L, Busy_H
  );

endinterface

// File: rtl/bus_wait_counter.sv
// Loadable down-counter with a zero flag; counts the wait states of a cycle.
module bus_wait_counter
  import bus_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  // Load wins over decrement; the counter holds at zero.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_dtack_responder.sv
// 68000 bus-cycle terminator: issues DTACK after per-region wait states,
// forwards DRAM/CAN acknowledges, and (with BUS_TIMEOUT_EN defined) raises
// BERR on cycles nobody terminates.
module bus_dtack_responder
  import bus_resp_pkg::*;
#(
  parameter int unsigned ROM_WAIT       = 0,
  parameter int unsigned RAM_WAIT       = 1,
  parameter int unsigned IO_WAIT        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  Clk,
  input  logic                  Reset_L,
  bus_dtack_responder_if.slave  bus
);

  state_t            state_q, state_d;
  region_t           region_q, region_d;
  region_t           region_sel;
  logic [WAIT_W-1:0] wait_init;
  logic              wait_load;
  logic              wait_dec;
  logic              wait_zero;
  logic              ack;
  logic              expire;
  logic              dtack_q;
  logic              busy_q;

  assign region_sel = decode_region(bus.OnChipRomSelect_H, bus.OnChipRamSelect_H,
                                    bus.DramSelect_H, bus.IOSelect_H,
                                    bus.CanBusSelect_H);

  // Wait count for the region being latched; external and unmapped regions start at 0.
  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wait_init = '0;
    case (region_sel)
      REG_ROM: wait_init = WAIT_W'(ROM_WAIT);
      REG_RAM: wait_init = WAIT_W'(RAM_WAIT);
      REG_IO:  wait_init = WAIT_W'(IO_WAIT);
      default: wait_init = '0;
    endcase
  end

  bus_wait_counter u_wait_counter (
    .clk      (Clk),
    .rst_n    (Reset_L),
    .load     (wait_load),
    .load_val (wait_init),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

`ifdef BUS_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_inc;

  // Saturating increment; expiry is judged on the value this WAIT cycle reaches.
  assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
  assign expire  = (state_q == WAIT) && (tmo_inc == TMO_W'(TIMEOUT_CYCLES));

  // Timeout counter: cleared when a cycle starts, counts every WAIT cycle.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L)
      tmo_q <= '0;
    else if ((state_q == IDLE) && !bus.AS_L)
      tmo_q <= '0;
    else if (state_q == WAIT)
      tmo_q <= tmo_inc;
  end
`else
  assign expire = 1'b0;
`endif

  // Next-state logic: region latch, wait/ack decisions, abort and timeout.
  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    wait_load = 1'b0;
    wait_dec  = 1'b0;
    ack       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.AS_L) begin
          state_d   = WAIT;
          region_d  = region_sel;
          wait_load = 1'b1;
        end
      end
      WAIT: begin
        if (bus.AS_L) begin
          state_d = IDLE;  // CPU abandoned the cycle: no DTACK, no BERR
        end else begin
          case (region_q)
            REG_ROM, REG_RAM, REG_IO: begin
              ack      = wait_zero;
              wait_dec = !wait_zero;
            end
            REG_DRAM: ack = !bus.DramDtack_L;
            REG_CAN:  ack = !bus.CanBusDtack_L;
`ifdef BUS_TIMEOUT_EN
            default:  ack = 1'b0;  // unmapped: left for the timeout to catch
`else
            default:  ack = wait_zero;  // unmapped: counter was loaded with 0
`endif
          endcase
          // An acknowledge on the expiry edge takes precedence over BERR.
          if (ack)
            state_d = ACK;
          else if (expire)
            state_d = ERR;
        end
      end
      ACK: begin
        if (bus.AS_L)
          state_d = IDLE;
      end
      ERR: begin
        if (bus.AS_L)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q  <= IDLE;
      region_q <= REG_NONE;
      dtack_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      dtack_q  <= (state_d != ACK);
      busy_q   <= (state_d != IDLE);
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic berr_q;

  // Registered bus error, low only while in ERR.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L)
      berr_q <= 1'b1;
    else
      berr_q <= (state_d != ERR);
  end

  assign bus.BERR_L = berr_q;
`else
  assign bus.BERR_L = 1'b1;
`endif

  assign bus.DtackOut_L = dtack_q;
  assign bus.Busy_H     = busy_q;

endmodule

// File: tb/tb_bus_dtack_responder.sv
// Directed scoreboard bench for bus_dtack_responder; follows BUS_TIMEOUT_EN.
module tb_bus_dtack_responder;
  import bus_resp_pkg::*;

  localparam int ROM_W = 0;
  localparam int RAM_W = 1;
  localparam int IO_W  = 3;
  localparam int TMO   = 15;

  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_BERR = 2;

  localparam logic [4:0] S_ROM  = 5'b10000;
  localparam logic [4:0] S_RAM  = 5'b01000;
  localparam logic [4:0] S_DRAM = 5'b00100;
  localparam logic [4:0] S_IO   = 5'b00010;
  localparam logic [4:0] S_CAN  = 5'b00001;
  localparam logic [4:0] S_NONE = 5'b00000;

  typedef struct {
    string tag;
    int    lat;
    int    kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   overlap = 0;
  int   berr_falls = 0;
  exp_t sb[$];

  bus_dtack_responder_if bus ();

  bus_dtack_responder #(
    .ROM_WAIT       (ROM_W),
    .RAM_WAIT       (RAM_W),
    .IO_WAIT        (IO_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clk     (clk),
    .Reset_L (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.DtackOut_L === 1'b0 && bus.BERR_L === 1'b0) overlap++;

  always @(negedge bus.BERR_L) berr_falls++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.AS_L = 1'b1;
    {bus.OnChipRomSelect_H, bus.OnChipRamSelect_H, bus.DramSelect_H,
     bus.IOSelect_H, bus.CanBusSelect_H} = S_NONE;
    bus.DramDtack_L   = 1'b1;
    bus.CanBusDtack_L = 1'b1;
  endtask

  // Present selects with AS_L low; returns just after the sampling edge (edge 0).
  task automatic start(input logic [4:0] sel);
    {bus.OnChipRomSelect_H, bus.OnChipRamSelect_H, bus.DramSelect_H,
     bus.IOSelect_H, bus.CanBusSelect_H} = sel;
    bus.AS_L = 1'b0;
    tick();
  endtask

  // Count edges until DTACK or BERR falls, bounded by limit.
  task automatic wait_term(input int limit, output int lat, output int kind);
    lat  = 0;
    kind = K_NONE;
    for (int i = 0; i < limit; i++) begin
      tick();
      lat++;
      if (bus.DtackOut_L === 1'b0) begin kind = K_ACK;  break; end
      if (bus.BERR_L === 1'b0)     begin kind = K_BERR; break; end
    end
  endtask

  task automatic score(input int lat, input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_kind"}, kind, e.kind);
      check({e.tag, "_latency"}, lat, e.lat);
    end
  endtask

  // Release AS_L and confirm the responder returns to idle on that edge.
  task automatic finish_cycle(input string tag);
    idle_bus();
    tick();
    check({tag, "_end_dtack"}, int'(bus.DtackOut_L), 1);
    check({tag, "_end_berr"}, int'(bus.BERR_L), 1);
    check({tag, "_end_busy"}, int'(bus.Busy_H), 0);
  endtask

  task automatic push(input string tag, input int lat, input int kind);
    exp_t e;
    e.tag  = tag;
    e.lat  = lat;
    e.kind = kind;
    sb.push_back(e);
  endtask

  initial begin
    int lat, kind, hi_viol;
    rst_n = 1'b1;
    idle_bus();
    #2 rst_n = 1'b0;
    #1;
    check("reset_dtack", int'(bus.DtackOut_L), 1);
    check("reset_berr", int'(bus.BERR_L), 1);
    check("reset_busy", int'(bus.Busy_H), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ROM, zero wait: DTACK at edge 1, held until AS_L high sampled at edge 4.
    push("rom", ROM_W + 1, K_ACK);
    start(S_ROM);
    wait_term(50, lat, kind);
    score(lat, kind);
    tick();
    tick();
    check("rom_hold_dtack", int'(bus.DtackOut_L), 0);
    finish_cycle("rom");

    // IO, three waits.
    push("io", IO_W + 1, K_ACK);
    start(S_IO);
    check("io_busy", int'(bus.Busy_H), 1);
    wait_term(50, lat, kind);
    score(lat, kind);
    finish_cycle("io");

    // RAM and IO both selected: RAM has priority.
    push("ram_io", RAM_W + 1, K_ACK);
    start(S_RAM | S_IO);
    wait_term(50, lat, kind);
    score(lat, kind);
    finish_cycle("ram_io");

    // DRAM: acknowledge withheld for 7 cycles, then forwarded one edge later.
    start(S_DRAM);
    hi_viol = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.DtackOut_L !== 1'b1) hi_viol++;
    end
    check("dram_held_off", hi_viol, 0);
    push("dram", 1, K_ACK);
    bus.DramDtack_L = 1'b0;
    wait_term(50, lat, kind);
    score(lat, kind);
    finish_cycle("dram");

    // DRAM acknowledge during an IO cycle is ignored.
    push("io_dram_ack", IO_W + 1, K_ACK);
    bus.DramDtack_L = 1'b0;
    start(S_IO);
    wait_term(50, lat, kind);
    score(lat, kind);
    finish_cycle("io_dram_ack");

    // Unmapped address.
`ifdef BUS_TIMEOUT_EN
    push("unmapped", TMO, K_BERR);
    start(S_NONE);
    wait_term(100, lat, kind);
    score(lat, kind);
    check("unmapped_dtack", int'(bus.DtackOut_L), 1);
    tick();
    check("unmapped_berr_hold", int'(bus.BERR_L), 0);
    finish_cycle("unmapped");

    // CAN acknowledge on the expiry edge beats BERR.
    push("can_race", TMO, K_ACK);
    start(S_CAN);
    for (int i = 0; i < TMO - 1; i++) tick();
    bus.CanBusDtack_L = 1'b0;
    wait_term(50, lat, kind);
    score(lat + TMO - 1, kind);
    check("can_race_berr", int'(bus.BERR_L), 1);
    finish_cycle("can_race");
`else
    push("unmapped", 1, K_ACK);
    start(S_NONE);
    wait_term(50, lat, kind);
    score(lat, kind);
    finish_cycle("unmapped");

    // CAN waits indefinitely for its acknowledge.
    push("can_slow", 40, K_ACK);
    start(S_CAN);
    for (int i = 0; i < 39; i++) tick();
    bus.CanBusDtack_L = 1'b0;
    wait_term(50, lat, kind);
    score(lat + 39, kind);
    finish_cycle("can_slow");
`endif

    // Abort during IO wait: no DTACK, and the next cycle runs normally.
    start(S_IO);
    tick();
    tick();
    bus.AS_L = 1'b1;
    tick();
    check("abort_busy", int'(bus.Busy_H), 0);
    hi_viol = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.DtackOut_L !== 1'b1 || bus.BERR_L !== 1'b1) hi_viol++;
    end
    check("abort_no_term", hi_viol, 0);
    push("after_abort", ROM_W + 1, K_ACK);
    start(S_ROM);
    wait_term(50, lat, kind);
    score(lat, kind);

    // Reset asserted while in ACK: DTACK released without waiting for a clock.
    #2 rst_n = 1'b0;
    #1;
    check("rst_ack_dtack", int'(bus.DtackOut_L), 1);
    check("rst_ack_busy", int'(bus.Busy_H), 0);
    idle_bus();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_ack_idle", int'(bus.Busy_H), 0);
    push("after_reset", RAM_W + 1, K_ACK);
    start(S_RAM);
    wait_term(50, lat, kind);
    score(lat, kind);
    finish_cycle("after_reset");

    check("scoreboard_drained", sb.size(), 0);
    check("dtack_berr_overlap", overlap, 0);
`ifdef BUS_TIMEOUT_EN
    check("berr_events", berr_falls, 1);
`else
    check("berr_events", berr_falls, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_dtack_responder.md
Name: bus_dtack_responder

Overview:
- Responder side of the 68000 asynchronous bus: consumes the address-decoder select lines and the CPU strobes, then terminates each bus cycle.
- Drives DtackOut_L after a programmable wait count for each on-chip region.
- Forwards the DTACK from the DRAM and CAN controllers.
- Raises BERR_L on unmapped or hung cycles. It sits between the address decoder and the CPU DTACK/BERR inputs.

Parameters:
- ROM_WAIT, 0, wait cycles for on-chip ROM (0..15)
- RAM_WAIT, 1, wait cycles for on-chip RAM (0..15)
- IO_WAIT, 3, wait cycles for the IO region (0..15)
- TIMEOUT_CYCLES, 1023, cycles before BERR on an unterminated cycle (1..65535)

Ports:
- Clk  in  1  system clock
- Reset_L  in  1  asynchronous active-low reset
- AS_L  in  1  CPU address strobe
- OnChipRomSelect_H  in  1  decoder select
- OnChipRamSelect_H  in  1  decoder select
- DramSelect_H  in  1  decoder select
- IOSelect_H  in  1  decoder select
- CanBusSelect_H  in  1  decoder select
- DramDtack_L  in  1  DRAM controller acknowledge
- CanBusDtack_L  in  1  CAN controller acknowledge
- DtackOut_L  out  1  registered DTACK to CPU
- BERR_L  out  1  registered bus error to CPU
- Busy_H  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, Reset_L low): state IDLE, counters 0, DtackOut_L=1, BERR_L=1, Busy_H=0. Reset mid-cycle aborts immediately and no acknowledge is issued.
- Region latch: in IDLE, the first edge that samples AS_L=0 latches the region (ROM, RAM, DRAM, IO, CAN or NONE) and moves to WAIT. The wait counter loads with the region's parameter; external regions load 0.
- Select priority when several selects are high: ROM > RAM > DRAM > IO > CAN.
- WAIT, internal region (ROM/RAM/IO): the counter decrements each cycle. When it is 0, move to ACK. DtackOut_L goes low exactly W+1 edges after the sampling edge, where W is the region's wait count (W=0 gives 1 cycle).
- WAIT, external region (DRAM/CAN): move to ACK on the first edge that samples the region's Dtack_L=0. The input is sampled directly with no synchroniser; it is already synchronous.
- ACK: DtackOut_L=0 until an edge samples AS_L=1. On that edge DtackOut_L returns to 1, the state goes to IDLE, and a new cycle can start on the next edge.
- Abort: if AS_L is sampled high in WAIT, return to IDLE with no DTACK and no BERR.
- Timeout counter: 16-bit. Clears on IDLE->WAIT, increments every WAIT cycle, and saturates (never wraps).
- Timeout expiry: when the count equals TIMEOUT_CYCLES, move to ERR.
- ERR: BERR_L=0 and DtackOut_L=1 until AS_L is sampled high, then IDLE.
- Simultaneous events: if an external Dtack_L=0 and timeout expiry occur on the same edge, ACK wins. DtackOut_L and BERR_L are never low together.
- NONE region: stays in WAIT, so it always times out (when BUS_TIMEOUT_EN is defined).

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: timeout counter, ERR state and BERR_L behave as described above.
- Undefined: no timeout counter and no ERR state; BERR_L is constant 1.
- Undefined, NONE region: acknowledged as W=0 (DtackOut_L low one cycle after the sampling edge), so the CPU never hangs.
- Undefined, external region: waits indefinitely for its Dtack_L.

Decomposition:
- Shared package bus_resp_pkg:
  - enum state_t {IDLE, WAIT, ACK, ERR}
  - enum region_t {REG_NONE, REG_ROM, REG_RAM, REG_DRAM, REG_IO, REG_CAN}
  - constant WAIT_W=4
  - constant TMO_W=16
- Sub-module bus_wait_counter: loadable down-counter with zero flag, reused for the wait count.
- The timeout counter stays inline, under ifdef.

Test Plan:
- ROM, ROM_WAIT=0: AS_L low sampled at edge 0 -> DtackOut_L low from edge 1; AS_L high sampled at edge 4 -> DtackOut_L high after edge 4, Busy_H=0.
- IO, IO_WAIT=3: AS_L low sampled at edge 0 -> DtackOut_L low from edge 4, never earlier; RAM+IO selects both high -> RAM timing (RAM_WAIT=1, low from edge 2).
- DRAM: DramDtack_L held high 7 cycles, then low -> DtackOut_L low one edge later; DramDtack_L on an IO cycle -> ignored.
- Unmapped address, BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=15 -> BERR_L low after 15 WAIT cycles, DtackOut_L stays 1; CanBusDtack_L asserted on the expiry edge -> DTACK instead, BERR_L stays 1.
- Abort and reset: AS_L deasserted during IO wait -> no DTACK and next cycle accepted normally; Reset_L pulsed low during ACK -> DtackOut_L=1 immediately (async), IDLE.
- BUS_TIMEOUT_EN undefined: unmapped cycle -> DtackOut_L low one cycle after the sampling edge; BERR_L constant 1 for the whole run.
